sram_arbiter: RTL and testbench
===============================

SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 15: maximum number of BUSY cycles allowed before a transfer is aborted.
REQ-002 Port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-003 Port rst, input, 1: asynchronous, active-high reset.
REQ-004 Ports m0_rd_en / m0_wr_en, input, 1 each: master 0 read / write request, held high until m0_ready=1.
REQ-005 Ports m0_addr / m0_wdata, input, 32 each: master 0 byte address / write data, stable while requesting.
REQ-006 Port m0_rdata, output, 32: master 0 read data, registered.
REQ-007 Port m0_ready, output, 1: master 0 stall release; low means stall.
REQ-008 Port m0_err, output, 1: master 0 timeout flag, one-cycle pulse.
REQ-009 Ports m1_rd_en, m1_wr_en, m1_addr, m1_wdata, m1_rdata, m1_ready, m1_err: master 1 equivalents of REQ-004..008, same directions and widths.
REQ-010 Ports mem_rd_en / mem_wr_en, output, 1 each: read / write enable to the SRAM controller.
REQ-011 Ports mem_addr / mem_wdata, output, 32 each: address / write data to the SRAM controller, passed through with no translation.
REQ-012 Port mem_rdata, input, 32: read data from the SRAM controller.
REQ-013 Port mem_ready, input, 1: SRAM controller completion; low while busy with enables high.

Function
REQ-014 The FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-015 In IDLE, a pending request (rd_en|wr_en) from any master SHALL cause a grant on the next edge: latch master id, op, addr and wdata; go to BUSY.
REQ-016 On simultaneous requests, the grant SHALL go to the master not granted last; the last-grant register resets to 1, so master 0 wins first.
REQ-017 When a granted master has both rd_en and wr_en high, the arbiter SHALL perform a write only.
REQ-018 In BUSY, exactly one of mem_wr_en / mem_rd_en (per the latched op) SHALL be high, and mem_addr / mem_wdata SHALL come from the latched values.
REQ-019 In BUSY, the arbiter SHALL sample mem_ready each cycle; on mem_ready=1 it goes to DONE and, for reads, captures mem_rdata into the granted master's rdata on that same edge.
REQ-020 In BUSY, a counter SHALL start at 0 on entry and increment each cycle; if it reaches TIMEOUT without mem_ready=1, the FSM goes to DONE with an error flag set and rdata unchanged.
REQ-021 In DONE, mem_rd_en, mem_wr_en, mem_addr and mem_wdata SHALL all be 0, giving the one-cycle enable drop the SRAM controller needs to reset its FSM; DONE always goes to IDLE.
REQ-022 mX_ready SHALL be 0 when master X requests and is not in DONE-for-X, and 1 otherwise; it is combinational from state and the request inputs.
REQ-023 mX_err SHALL be high only in a DONE-for-X cycle entered via timeout.
REQ-024 A master still requesting in the IDLE cycle after its DONE SHALL be treated as a new request.
REQ-025 The non-granted master SHALL see ready=0 throughout the other master's transfer.
REQ-026 Minimum turnaround SHALL be request -> BUSY (1 cycle) + downstream latency + DONE (1 cycle) + IDLE (1 cycle).
REQ-027 mX_rdata SHALL hold its value until that master's next successful read.

Reset
REQ-028 While rst=1, the arbiter SHALL immediately enter IDLE, including mid-transfer, with the last-grant register=1 and the BUSY counter=0.
REQ-029 While rst=1, all mem_* outputs SHALL be 0, m0_rdata/m1_rdata SHALL be 0 and m0_err/m1_err SHALL be 0.
REQ-030 While rst=1, mX_ready SHALL follow REQ-022 (1 when X is idle).

Verification
REQ-031 m0 write addr 0x400, data 0xDEADBEEF; model mem_ready high 4 cycles after BUSY entry -> mem_wr_en high for 5 cycles, then 0 for 1 cycle; m0_ready=1 only in the DONE cycle.
REQ-032 m0 and m1 read in the same cycle after reset -> m0 served first and m1 next; m1_ready=0 throughout m0's transfer.
REQ-033 Both masters requesting continuously -> grants alternate 0,1,0,1; no master is granted twice in a row.
REQ-034 m1 read with mem_rdata=0x12345678 at completion -> m1_rdata=0x12345678 from the DONE cycle onward; m0_rdata unchanged.
REQ-035 mem_ready held 0 -> after 15 BUSY cycles, DONE with mX_err=1 for one cycle and rdata unchanged.
REQ-036 rst asserted in the 3rd BUSY cycle -> mem_rd_en and mem_wr_en drop to 0 in the same cycle, state is IDLE, and the next request goes to master 0.

Source files
------------

// File: rtl/sram_arbiter.sv
// sram_arbiter: round-robin arbiter sharing one SRAM controller between two masters,
// with a per-transfer BUSY timeout that aborts and flags the stalled master.
module sram_arbiter #(
   parameter int TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        m0_rd_en,
   input  logic        m0_wr_en,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   output logic [31:0] m0_rdata,
   output logic        m0_ready,
   output logic        m0_err,
   input  logic        m1_rd_en,
   input  logic        m1_wr_en,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   output logic [31:0] m1_rdata,
   output logic        m1_ready,
   output logic        m1_err,
   output logic        mem_rd_en,
   output logic        mem_wr_en,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready
);
   localparam int CW = $clog2(TIMEOUT + 1);
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   state_t r_state, w_next;
   logic [CW-1:0] r_cnt;
   logic r_gnt, r_last, r_wr, r_err;
   logic [31:0] r_addr, r_wdata, r_rdata0, r_rdata1;
   logic w_req0, w_req1, w_pick, w_tmo, w_grant;
   assign w_req0 = m0_rd_en | m0_wr_en;
   assign w_req1 = m1_rd_en | m1_wr_en;
   // on contention the master not served last wins
   assign w_pick = (w_req0 & w_req1) ? ~r_last : w_req1;
   assign w_grant = (r_state == IDLE) & (w_req0 | w_req1);
   assign w_tmo = r_cnt == CW'(TIMEOUT - 1);
   assign m0_ready = ~(w_req0 & ~((r_state == DONE) & ~r_gnt));
   assign m1_ready = ~(w_req1 & ~((r_state == DONE) & r_gnt));
   assign m0_err = (r_state == DONE) & r_err & ~r_gnt;
   assign m1_err = (r_state == DONE) & r_err & r_gnt;
   assign m0_rdata = r_rdata0;
   assign m1_rdata = r_rdata1;
   always_comb begin
      w_next = r_state;
      mem_rd_en = 1'b0;
      mem_wr_en = 1'b0;
      mem_addr = 32'd0;
      mem_wdata = 32'd0;
      if (w_grant) w_next = BUSY;
      else if (r_state == BUSY && (mem_ready | w_tmo)) w_next = DONE;
      else if (r_state == DONE) w_next = IDLE;
      if (r_state == BUSY) begin
         mem_rd_en = ~r_wr;
         mem_wr_en = r_wr;
         mem_addr = r_addr;
         mem_wdata = r_wdata;
      end
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) r_state <= IDLE;
      else r_state <= w_next;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_gnt <= 1'b0;
         r_last <= 1'b1;
         r_wr <= 1'b0;
         r_err <= 1'b0;
         r_cnt <= '0;
         r_addr <= 32'd0;
         r_wdata <= 32'd0;
         r_rdata0 <= 32'd0;
         r_rdata1 <= 32'd0;
      end else if (w_grant) begin
         r_gnt <= w_pick;
         r_last <= w_pick;
         r_wr <= w_pick ? m1_wr_en : m0_wr_en;
         r_addr <= w_pick ? m1_addr : m0_addr;
         r_wdata <= w_pick ? m1_wdata : m0_wdata;
         r_cnt <= '0;
         r_err <= 1'b0;
      end else if (r_state == BUSY) begin
         r_cnt <= r_cnt + CW'(1);
         r_err <= ~mem_ready & w_tmo;
         if (mem_ready & ~r_wr & r_gnt) r_rdata1 <= mem_rdata;
         if (mem_ready & ~r_wr & ~r_gnt) r_rdata0 <= mem_rdata;
      end
   end
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed and randomized checks of sram_arbiter against a
// transaction-level model of memory contents, read data, fairness and timeouts.
module tb_sram_arbiter;
   localparam int TIMEOUT = 15;
   logic clk = 1'b0;
   logic rst;
   logic m0_rd_en, m0_wr_en, m1_rd_en, m1_wr_en;
   logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
   logic [31:0] m0_rdata, m1_rdata;
   logic m0_ready, m0_err, m1_ready, m1_err;
   logic mem_rd_en, mem_wr_en, mem_ready;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   int total = 0;
   int bad = 0;
   always #5 clk = ~clk;

   sram_arbiter #(.TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst),
      .m0_rd_en(m0_rd_en), .m0_wr_en(m0_wr_en), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_rdata(m0_rdata), .m0_ready(m0_ready), .m0_err(m0_err),
      .m1_rd_en(m1_rd_en), .m1_wr_en(m1_wr_en), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_rdata(m1_rdata), .m1_ready(m1_ready), .m1_err(m1_err),
      .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
   );

   // SRAM controller model: completes after cur_lat busy cycles, never if cur_lat >= TIMEOUT
   bit [31:0] sram [0:1023];
   bit [31:0] ref_mem [0:1023];
   logic [31:0] exp_rd [2];
   int busy_cnt, cur_lat, fix_lat;
   logic w_en;
   assign w_en = mem_rd_en | mem_wr_en;
   assign mem_ready = w_en && (busy_cnt == cur_lat);
   assign mem_rdata = sram[mem_addr[11:2]];
   always @(posedge clk) begin
      busy_cnt <= w_en ? busy_cnt + 1 : 0;
      if (mem_wr_en && mem_ready) sram[mem_addr[11:2]] <= mem_wdata;
      if (!w_en) cur_lat <= (fix_lat >= 0) ? fix_lat : ((($urandom % 8) == 0) ? 99 : int'($urandom % 7));
   end

   task automatic idle_inputs();
      m0_rd_en = 0; m0_wr_en = 0; m1_rd_en = 0; m1_wr_en = 0;
      m0_addr = 0; m0_wdata = 0; m1_addr = 0; m1_wdata = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1; idle_inputs();
      repeat (2) @(negedge clk);
      rst = 0;
      exp_rd[0] = 0; exp_rd[1] = 0;
   endtask

   task automatic release_all();
      @(negedge clk);
      m0_rd_en = 0; m0_wr_en = 0; m1_rd_en = 0; m1_wr_en = 0;
      #1;
   endtask

   task automatic run_xfer(input int m, input logic rd, input logic wr, input logic [31:0] a,
                           input logic [31:0] d, output int en_cyc, output bit ok);
      @(negedge clk);
      if (m == 0) begin m0_rd_en = rd; m0_wr_en = wr; m0_addr = a; m0_wdata = d; end
      else begin m1_rd_en = rd; m1_wr_en = wr; m1_addr = a; m1_wdata = d; end
      #1;
      en_cyc = 0; ok = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk); #1;
         if (w_en) en_cyc++;
         if ((m == 0) ? m0_ready : m1_ready) begin ok = 1; break; end
      end
   endtask

   task automatic test_reset();
      fix_lat = 0;
      rst = 1; idle_inputs();
      repeat (2) @(negedge clk);
      #1;
      total++; if ({mem_rd_en, mem_wr_en, mem_addr, mem_wdata} !== 66'd0) begin bad++; $display("FAIL reset_mem: got %h want 0", {mem_rd_en, mem_wr_en, mem_addr, mem_wdata}); end
      total++; if ({m0_rdata, m1_rdata} !== 64'd0) begin bad++; $display("FAIL reset_rdata: got %h want 0", {m0_rdata, m1_rdata}); end
      total++; if ({m0_err, m1_err, m0_ready, m1_ready} !== 4'b0011) begin bad++; $display("FAIL reset_flags: got %b want 0011", {m0_err, m1_err, m0_ready, m1_ready}); end
      m1_rd_en = 1; #1;
      total++; if ({m1_ready, mem_rd_en} !== 2'b00) begin bad++; $display("FAIL reset_req_ready: got %b want 00", {m1_ready, mem_rd_en}); end
      m1_rd_en = 0;
      @(negedge clk);
      rst = 0;
      exp_rd[0] = 0; exp_rd[1] = 0;
   endtask

   task automatic test_write();
      int wr_cyc = 0;
      bit done = 0;
      @(negedge clk);
      fix_lat = 4; m0_wr_en = 1; m0_addr = 32'h400; m0_wdata = 32'hDEADBEEF;
      #1;
      total++; if (m0_ready !== 1'b0) begin bad++; $display("FAIL wr_stall: got %b want 0", m0_ready); end
      for (int i = 0; i < 30 && !done; i++) begin
         @(negedge clk); #1;
         if (mem_wr_en) begin
            wr_cyc++;
            total++; if ({mem_rd_en, mem_addr, mem_wdata} !== {1'b0, 32'h400, 32'hDEADBEEF}) begin bad++; $display("FAIL wr_bus: got %h want 0_00000400_deadbeef", {mem_rd_en, mem_addr, mem_wdata}); end
         end
         if (m0_ready) begin
            done = 1;
            total++; if (wr_cyc !== 5) begin bad++; $display("FAIL wr_len: got %0d want 5", wr_cyc); end
            total++; if ({mem_rd_en, mem_wr_en, mem_addr, mem_wdata} !== 66'd0) begin bad++; $display("FAIL wr_drop: got %h want 0", {mem_rd_en, mem_wr_en, mem_addr, mem_wdata}); end
         end
      end
      total++; if (!done) begin bad++; $display("FAIL wr_done: got no ready want ready"); end
      ref_mem[10'h100] = 32'hDEADBEEF;
      release_all();
      total++; if ({m0_ready, mem_wr_en} !== 2'b10) begin bad++; $display("FAIL wr_idle: got %b want 10", {m0_ready, mem_wr_en}); end
      total++; if (sram[10'h100] !== ref_mem[10'h100]) begin bad++; $display("FAIL wr_mem: got %h want %h", sram[10'h100], ref_mem[10'h100]); end
   endtask

   task automatic test_simul();
      logic [31:0] order[$];
      int dn[$];
      bit pe = 0, f0 = 0, f1 = 0;
      do_reset();
      @(negedge clk);
      fix_lat = 2;
      m0_rd_en = 1; m0_addr = 32'h10; m1_rd_en = 1; m1_addr = 32'h20;
      #1;
      for (int i = 0; i < 40 && dn.size() < 2; i++) begin
         @(negedge clk);
         if (f0) m0_rd_en = 0;
         if (f1) m1_rd_en = 0;
         #1;
         if (w_en && !pe) order.push_back(mem_addr);
         pe = w_en;
         if (dn.size() == 0) begin
            total++; if (m1_ready !== 1'b0) begin bad++; $display("FAIL sim_m1_stall: got %b want 0", m1_ready); end
         end
         if (m0_rd_en && m0_ready && !f0) begin dn.push_back(0); f0 = 1; end
         if (m1_rd_en && m1_ready && !f1) begin dn.push_back(1); f1 = 1; end
      end
      total++; if (dn.size() !== 2) begin bad++; $display("FAIL sim_count: got %0d want 2", dn.size()); end
      else begin
         total++; if (dn[0] !== 0 || dn[1] !== 1) begin bad++; $display("FAIL sim_order: got %0d,%0d want 0,1", dn[0], dn[1]); end
      end
      total++; if (order.size() !== 2) begin bad++; $display("FAIL sim_xfers: got %0d want 2", order.size()); end
      else begin
         total++; if (order[0] !== 32'h10 || order[1] !== 32'h20) begin bad++; $display("FAIL sim_addr: got %h,%h want 10,20", order[0], order[1]); end
      end
      exp_rd[0] = ref_mem[4]; exp_rd[1] = ref_mem[8];
      release_all();
      total++; if ({m0_rdata, m1_rdata} !== {exp_rd[0], exp_rd[1]}) begin bad++; $display("FAIL sim_rdata: got %h want %h", {m0_rdata, m1_rdata}, {exp_rd[0], exp_rd[1]}); end
   endtask

   task automatic test_alternate();
      int seq[$];
      @(negedge clk);
      fix_lat = 1;
      m0_rd_en = 1; m0_addr = 32'h10; m1_rd_en = 1; m1_addr = 32'h20;
      #1;
      for (int i = 0; i < 100 && seq.size() < 8; i++) begin
         @(negedge clk); #1;
         if (m0_ready) seq.push_back(0);
         if (m1_ready) seq.push_back(1);
      end
      total++; if (seq.size() !== 8) begin bad++; $display("FAIL alt_count: got %0d want 8", seq.size()); end
      else begin
         total++; if (seq[0] !== 0) begin bad++; $display("FAIL alt_first: got %0d want 0", seq[0]); end
         for (int i = 1; i < 8; i++) begin
            total++; if (seq[i] !== 1 - seq[i-1]) begin bad++; $display("FAIL alt_seq[%0d]: got %0d want %0d", i, seq[i], 1 - seq[i-1]); end
         end
      end
      release_all();
   endtask

   task automatic test_m1_read();
      int n;
      bit ok;
      fix_lat = 3;
      run_xfer(0, 1'b0, 1'b1, 32'h30, 32'h12345678, n, ok);
      total++; if (!ok) begin bad++; $display("FAIL m1rd_pre: got no ready want ready"); end
      ref_mem[12] = 32'h12345678;
      release_all();
      run_xfer(1, 1'b1, 1'b0, 32'h30, 32'h0, n, ok);
      total++; if (!ok) begin bad++; $display("FAIL m1rd_done: got no ready want ready"); end
      exp_rd[1] = ref_mem[12];
      total++; if (m1_rdata !== 32'h12345678) begin bad++; $display("FAIL m1rd_data: got %h want 12345678", m1_rdata); end
      total++; if (m0_rdata !== exp_rd[0]) begin bad++; $display("FAIL m1rd_m0: got %h want %h", m0_rdata, exp_rd[0]); end
      release_all();
      repeat (3) @(negedge clk);
      #1;
      total++; if ({m0_rdata, m1_rdata} !== {exp_rd[0], 32'h12345678}) begin bad++; $display("FAIL m1rd_hold: got %h want %h", {m0_rdata, m1_rdata}, {exp_rd[0], 32'h12345678}); end
   endtask

   task automatic test_timeout();
      int n;
      bit ok;
      fix_lat = 99;
      run_xfer(0, 1'b1, 1'b0, 32'h40, 32'h0, n, ok);
      total++; if (!ok) begin bad++; $display("FAIL tmo_done: got no ready want ready"); end
      total++; if (n !== TIMEOUT) begin bad++; $display("FAIL tmo_len: got %0d want %0d", n, TIMEOUT); end
      total++; if ({m0_err, m1_err} !== 2'b10) begin bad++; $display("FAIL tmo_err: got %b want 10", {m0_err, m1_err}); end
      total++; if (m0_rdata !== exp_rd[0]) begin bad++; $display("FAIL tmo_rdata: got %h want %h", m0_rdata, exp_rd[0]); end
      release_all();
      total++; if ({m0_err, m1_err} !== 2'b00) begin bad++; $display("FAIL tmo_pulse: got %b want 00", {m0_err, m1_err}); end
   endtask

   task automatic test_reset_mid();
      int cnt = 0;
      bit f0 = 0, f1 = 0;
      @(negedge clk);
      fix_lat = 99;
      m0_rd_en = 1; m0_addr = 32'h50;
      #1;
      for (int i = 0; i < 10 && cnt < 3; i++) begin
         @(negedge clk); #1;
         if (w_en) cnt++;
      end
      total++; if (cnt !== 3) begin bad++; $display("FAIL rmid_busy: got %0d want 3", cnt); end
      rst = 1;
      #1;
      total++; if ({mem_rd_en, mem_wr_en, mem_addr} !== 34'd0) begin bad++; $display("FAIL rmid_drop: got %h want 0", {mem_rd_en, mem_wr_en, mem_addr}); end
      total++; if ({m0_ready, m0_rdata, m1_rdata} !== 65'd0) begin bad++; $display("FAIL rmid_state: got %h want 0", {m0_ready, m0_rdata, m1_rdata}); end
      exp_rd[0] = 0; exp_rd[1] = 0;
      @(negedge clk);
      rst = 0; fix_lat = 1;
      m1_rd_en = 1; m1_addr = 32'h60;
      @(negedge clk); #1;
      total++; if ({mem_rd_en, mem_addr} !== {1'b1, 32'h50}) begin bad++; $display("FAIL rmid_grant: got %h want 1_00000050", {mem_rd_en, mem_addr}); end
      for (int i = 0; i < 30 && !(f0 && f1); i++) begin
         if (m0_rd_en && m0_ready) f0 = 1;
         if (m1_rd_en && m1_ready) f1 = 1;
         @(negedge clk);
         if (f0) m0_rd_en = 0;
         if (f1) m1_rd_en = 0;
         #1;
      end
      total++; if (!(f0 && f1)) begin bad++; $display("FAIL rmid_finish: got %b%b want 11", f0, f1); end
   endtask

   task automatic test_random();
      bit act [2];
      bit rdq [2];
      bit wrq [2];
      logic [31:0] ad [2];
      logic [31:0] wd [2];
      int last_m, ndone, r;
      bit rdy, er, hang, exp_err;
      logic [31:0] rdat;
      fix_lat = -1;
      act[0] = 0; act[1] = 0;
      for (int ph = 0; ph < 2; ph++) begin
         last_m = -1; ndone = 0;
         for (int c = 0; c < 3000 && ndone < 40; c++) begin
            @(negedge clk);
            for (int m = 0; m < 2; m++) begin
               if (!act[m] && (ph == 0 || ($urandom % 3) == 0)) begin
                  act[m] = 1;
                  r = int'($urandom % 4);
                  wrq[m] = r >= 2;
                  rdq[m] = r != 2;
                  ad[m] = 32'h100 + 32'(($urandom % 16) << 2);
                  wd[m] = $urandom;
               end
            end
            m0_rd_en = act[0] & rdq[0]; m0_wr_en = act[0] & wrq[0]; m0_addr = ad[0]; m0_wdata = wd[0];
            m1_rd_en = act[1] & rdq[1]; m1_wr_en = act[1] & wrq[1]; m1_addr = ad[1]; m1_wdata = wd[1];
            #1;
            hang = cur_lat >= TIMEOUT;
            for (int m = 0; m < 2; m++) begin
               rdy = (m == 0) ? m0_ready : m1_ready;
               er = (m == 0) ? m0_err : m1_err;
               rdat = (m == 0) ? m0_rdata : m1_rdata;
               exp_err = act[m] && rdy && hang;
               if (act[m] && rdy) begin
                  if (!hang && wrq[m]) ref_mem[ad[m][11:2]] = wd[m];
                  if (!hang && !wrq[m]) exp_rd[m] = ref_mem[ad[m][11:2]];
                  if (ph == 0 && last_m >= 0) begin
                     total++; if (m == last_m) begin bad++; $display("FAIL rnd_fair: got master %0d twice want alternation", m); end
                  end
                  last_m = m; ndone++; act[m] = 0;
               end
               total++; if (er !== exp_err) begin bad++; $display("FAIL rnd_err m%0d: got %b want %b", m, er, exp_err); end
               total++; if (rdat !== exp_rd[m]) begin bad++; $display("FAIL rnd_rdata m%0d: got %h want %h", m, rdat, exp_rd[m]); end
            end
         end
         total++; if (ndone < 40) begin bad++; $display("FAIL rnd_budget ph%0d: got %0d want 40", ph, ndone); end
      end
   endtask

   initial begin
      rst = 1; idle_inputs(); fix_lat = 0;
      test_reset();
      test_write();
      test_simul();
      test_alternate();
      test_m1_read();
      test_timeout();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
